ifid_branch_unit: RTL
=====================

// Module: ifid_branch_unit
// PURPOSE
//  Decode-side partner of the fetch stage. Latches the fetched instruction and PC+4 into the IF/ID pipeline register.
//  Decodes control transfers in D. Drives Branch_Jump/PC_Update back to fetch, which loads PC_Update on its next enabled edge.
//  Architectural branch delay slot: the instruction after a branch always executes, never flushed.
// PARAMETERS
//  INIT_PC   32'h0000_3000  fetch reset address; PC4_D resets to INIT_PC+4
//  NOP_INSTR 32'h0000_0000  value loaded into Instr_D on reset
// PORTS
//  Clock         in   1   clock, posedge
//  Reset         in   1   synchronous, active-high
//  Enable        in   1   pipeline advance; 0 = stall (same signal that gates fetch PC)
//  Instr_F       in   32  instruction from fetch
//  PC4_F         in   32  PC+4 from fetch
//  RS_Data       in   32  forwarded rs value (branch compare, jr/jalr target)
//  RT_Data       in   32  forwarded rt value (branch compare)
//  Instr_D       out  32  registered instruction
//  PC4_D         out  32  registered PC+4
//  PC8_D         out  32  link address = PC4_D+4
//  Valid_D       out  1   Instr_D holds a real fetched instruction
//  Delay_Slot_D  out  1   Instr_D is the delay slot of a taken transfer
//  Branch_Jump   out  1   redirect fetch (combinational)
//  PC_Update     out  32  redirect target (combinational)
//  CT_Err_D      out  1   control transfer found in a delay slot (suppressed)
// BEHAVIOUR
//  Reset (posedge Clock, Reset=1; overrides Enable and any pending redirect):
//   Instr_D=NOP_INSTR, PC4_D=INIT_PC+4, Valid_D=0, Delay_Slot_D=0.
//  Enable=1: Instr_D<=Instr_F, PC4_D<=PC4_F, Valid_D<=1, Delay_Slot_D<=take (take = Branch_Jump this cycle). One-cycle latency F->D.
//  Enable=0: all registers hold. Branch_Jump/PC_Update stay live and may change with RS/RT_Data; fetch ignores them while stalled.
//  Decode of Instr_D (op=[31:26], funct=[5:0]):
//   beq 000100 taken if RS_Data==RT_Data
//   bne 000101 taken if RS_Data!=RT_Data
//   j 000010 / jal 000011 always taken
//   op 000000: jr (funct 001000) and jalr (funct 001001) always taken
//  Targets, 32-bit, wrap mod 2^32, no overflow flag:
//   branch = PC4_D + {{14{imm[15]}},imm[15:0],2'b00}
//   j/jal  = {PC4_D[31:28],Instr_D[25:0],2'b00}
//   jr/jalr = RS_Data, unaligned low bits passed through unchanged
//  Branch_Jump = decoded_take & Valid_D & ~Delay_Slot_D.
//  PC_Update = target when decoded as control transfer, else PC4_D+4 (don't-care but defined).
//  CT_Err_D = Valid_D & Delay_Slot_D & instruction is a control transfer; that transfer is never taken.
//  Delay slot: no flush. Instruction fetched at PC4_D enters D on the next enabled edge with Delay_Slot_D=1.
//   Fetch uses PC_Update at that same edge.
//  Stall with pending take: the taken decision is re-evaluated each cycle until Enable=1. Delay_Slot_D captures the value at the enabled edge.
// CONFIGURATION
//  Macro EXT_BRANCH_EN:
//   defined: also decodes blez 000110 (RS<=0 signed), bgtz 000111 (RS>0 signed),
//    and op 000001 regimm with rt=00000 bltz (RS<0) / rt=00001 bgez (RS>=0).
//    Target formula equals beq; all four count as control transfers for CT_Err_D.
//   undefined: those opcodes decode as non-transfers; Branch_Jump=0 for them.
// TESTING
//  Reset held 2 cycles, Instr_F=32'h1000_0003 -> Instr_D=0, PC4_D=32'h3004, Valid_D=0, Branch_Jump=0
//  beq 32'h1085_0003 at PC4_D=32'h3008, RS=RT=5 -> Branch_Jump=1, PC_Update=32'h3014; next edge Delay_Slot_D=1
//  bne imm 16'hFFFF at PC4_D=32'h3010, RS=1, RT=2 -> PC_Update=32'h300C; RS=RT -> Branch_Jump=0
//  j 32'h0800_0C10 at PC4_D=32'h3020 -> PC_Update=32'h3040; jr rs with RS_Data=32'h3100 -> PC_Update=32'h3100
//  j in delay slot of taken beq -> Branch_Jump=0, CT_Err_D=1; Enable=0 for 3 cycles -> Instr_D/PC4_D unchanged
//  EXT_BRANCH_EN: bltz, RS=32'hFFFF_FFFF -> taken; without macro -> Branch_Jump=0

Source files
------------

// File: rtl/ifid_branch_unit.sv
// IF/ID pipeline register with decode-stage branch/jump resolution and architectural delay slot.
// Optional macro EXT_BRANCH_EN adds blez/bgtz/bltz/bgez decoding.
module ifid_branch_unit #(
    parameter logic [31:0] INIT_PC   = 32'h0000_3000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Enable,
    input  logic [31:0] Instr_F,
    input  logic [31:0] PC4_F,
    input  logic [31:0] RS_Data,
    input  logic [31:0] RT_Data,
    output logic [31:0] Instr_D,
    output logic [31:0] PC4_D,
    output logic [31:0] PC8_D,
    output logic        Valid_D,
    output logic        Delay_Slot_D,
    output logic        Branch_Jump,
    output logic [31:0] PC_Update,
    output logic        CT_Err_D
);

    localparam logic [31:0] RESET_PC4 = INIT_PC + 32'd4;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_BNE     = 6'b000101;
    localparam logic [5:0] FN_JR      = 6'b001000;
    localparam logic [5:0] FN_JALR    = 6'b001001;
`ifdef EXT_BRANCH_EN
    localparam logic [5:0] OP_REGIMM  = 6'b000001;
    localparam logic [5:0] OP_BLEZ    = 6'b000110;
    localparam logic [5:0] OP_BGTZ    = 6'b000111;
`endif

    logic [5:0]  op;
    logic [5:0]  funct;
    logic [31:0] br_target;
    logic [31:0] j_target;
    logic        is_ct;
    logic        decoded_take;
    logic [31:0] target;

    // Enable is the only flow control: 1 advances F->D, 0 freezes every register.
    // There is no ready back-pressure; fetch is gated by the same Enable.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            Instr_D      <= NOP_INSTR;
            PC4_D        <= RESET_PC4;
            Valid_D      <= 1'b0;
            Delay_Slot_D <= 1'b0;
        end else if (Enable) begin
            Instr_D      <= Instr_F;
            PC4_D        <= PC4_F;
            Valid_D      <= 1'b1;
            Delay_Slot_D <= Branch_Jump;
        end
    end

    assign op        = Instr_D[31:26];
    assign funct     = Instr_D[5:0];
    assign PC8_D     = PC4_D + 32'd4;
    assign br_target = PC4_D + {{14{Instr_D[15]}}, Instr_D[15:0], 2'b00};
    assign j_target  = {PC4_D[31:28], Instr_D[25:0], 2'b00};

    always_comb begin
        is_ct        = 1'b0;
        decoded_take = 1'b0;
        target       = PC8_D;
        case (op)
            OP_BEQ: begin
                is_ct        = 1'b1;
                decoded_take = (RS_Data == RT_Data);
                target       = br_target;
            end
            OP_BNE: begin
                is_ct        = 1'b1;
                decoded_take = (RS_Data != RT_Data);
                target       = br_target;
            end
            OP_J, OP_JAL: begin
                is_ct        = 1'b1;
                decoded_take = 1'b1;
                target       = j_target;
            end
            OP_SPECIAL: begin
                if (funct == FN_JR || funct == FN_JALR) begin
                    is_ct        = 1'b1;
                    decoded_take = 1'b1;
                    target       = RS_Data;
                end
            end
`ifdef EXT_BRANCH_EN
            // Signed compares against zero reduce to the sign bit plus a zero test.
            OP_BLEZ: begin
                is_ct        = 1'b1;
                decoded_take = RS_Data[31] | (RS_Data == 32'd0);
                target       = br_target;
            end
            OP_BGTZ: begin
                is_ct        = 1'b1;
                decoded_take = ~RS_Data[31] & (RS_Data != 32'd0);
                target       = br_target;
            end
            OP_REGIMM: begin
                if (Instr_D[20:16] == 5'b00000) begin
                    is_ct        = 1'b1;
                    decoded_take = RS_Data[31];
                    target       = br_target;
                end else if (Instr_D[20:16] == 5'b00001) begin
                    is_ct        = 1'b1;
                    decoded_take = ~RS_Data[31];
                    target       = br_target;
                end
            end
`endif
            default: ;
        endcase
    end

    // A transfer sitting in a delay slot is flagged, never taken.
    assign Branch_Jump = decoded_take & Valid_D & ~Delay_Slot_D;
    assign PC_Update   = target;
    assign CT_Err_D    = Valid_D & Delay_Slot_D & is_ct;

endmodule
